// File: rtl/router_pkg.sv
// Shared router types: port count, destination index type and the
// per-output allocation state used by the switch allocator.
package router_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int DEST_WIDTH = 3;

  typedef logic [DEST_WIDTH-1:0] port_idx_t;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_e;

  localparam port_idx_t NUM_IDX = port_idx_t'(NUM_PORTS);

  function automatic port_idx_t onehot_to_idx(
    input logic [NUM_PORTS-1:0] oh
  );
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (oh[i]) onehot_to_idx = port_idx_t'(i);
  endfunction

  function automatic port_idx_t next_idx(input port_idx_t idx);
    if (idx == port_idx_t'(NUM_PORTS - 1))
      next_idx = '0;
    else
      next_idx = idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Buffer-side request bundle and allocator grant outputs.
// master = input buffers / switch side, slave = allocator.
interface switch_allocator_if
  import router_pkg::*;
();

  logic [NUM_PORTS-1:0] buf_req;
  port_idx_t [NUM_PORTS-1:0] buf_dest;
  logic [NUM_PORTS-1:0] buf_tail;
  logic [NUM_PORTS-1:0] buf_ack;
  logic [NUM_PORTS-1:0] buffer_grants;
  logic [NUM_PORTS-1:0] out_busy;
  logic dest_err;

  modport master (
    output buf_req, buf_dest, buf_tail, buf_ack,
    input  buffer_grants, out_busy, dest_err
  );

  modport slave (
    input  buf_req, buf_dest, buf_tail, buf_ack,
    output buffer_grants, out_busy, dest_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request scanning
// upward from ptr, wrapping modulo NUM_PORTS.
module rr_arbiter
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 valid
);

  logic [DEST_WIDTH:0]   sum;
  logic [DEST_WIDTH-1:0] idx;
  logic                  found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, ptr} + (DEST_WIDTH+1)'(k);
      if (sum >= (DEST_WIDTH+1)'(NUM_PORTS))
        idx = DEST_WIDTH'(sum - (DEST_WIDTH+1)'(NUM_PORTS));
      else
        idx = sum[DEST_WIDTH-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin allocation with wormhole locking: an output
// stays with its owner until the owner's tail flit is acknowledged.
module switch_allocator
  import router_pkg::*;
(
  input logic clk,
  input logic rst,
  switch_allocator_if.slave bus
);

  alloc_state_e state_q [NUM_PORTS];
  alloc_state_e state_d [NUM_PORTS];
  port_idx_t [NUM_PORTS-1:0] owner_q, owner_d;
  port_idx_t [NUM_PORTS-1:0] ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] grants_q, grants_d;
  logic [NUM_PORTS-1:0] busy_q, busy_d;
  logic err_q, err_d;

  logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_vld;

  // Already-granted buffers are locked elsewhere; out-of-range
  // destinations never match any output index.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        cand[o][i] = bus.buf_req[i]
                   && (bus.buf_dest[i] == port_idx_t'(o))
                   && !grants_q[i];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req   (cand[o]),
      .ptr   (ptr_q[o]),
      .gnt   (arb_gnt[o]),
      .valid (arb_vld[o])
    );
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grants_d = '0;
    busy_d   = '0;
    err_d    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (bus.buf_req[i] && bus.buf_dest[i] >= NUM_IDX)
        err_d = 1'b1;
    for (int o = 0; o < NUM_PORTS; o++) begin
      unique case (state_q[o])
        ALLOC_IDLE: begin
          if (arb_vld[o]) begin
            state_d[o] = ALLOC_LOCKED;
            owner_d[o] = onehot_to_idx(arb_gnt[o]);
          end
        end
        ALLOC_LOCKED: begin
          if (bus.buf_ack[owner_q[o]]
              && bus.buf_tail[owner_q[o]]) begin
            state_d[o] = ALLOC_IDLE;
            ptr_d[o]   = next_idx(owner_q[o]);
          end
        end
        default: state_d[o] = ALLOC_IDLE;
      endcase
      if (state_d[o] == ALLOC_LOCKED) begin
        grants_d[owner_d[o]] = 1'b1;
        busy_d[o]            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS; o++)
        state_q[o] <= ALLOC_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      grants_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      grants_q <= grants_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.buffer_grants = grants_q;
  assign bus.out_busy      = busy_q;
  assign bus.dest_err      = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scenarios plus randomized traffic against a queue-free
// per-output lock/pointer reference model.
module tb_switch_allocator;
  import router_pkg::*;

  logic clk;
  logic rst;
  int checks;
  int errors;

  switch_allocator_if tif ();

  switch_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per output, a lock flag, an owner and a pointer.
  bit       m_lock [5];
  int       m_own  [5];
  int       m_ptr  [5];
  bit [4:0] m_grants;
  bit [4:0] m_busy;
  bit       m_err;
  bit [4:0] nxt_g;
  bit       hit;
  int       j;

  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 5; o++) begin
        m_lock[o] = 0;
        m_own[o]  = 0;
        m_ptr[o]  = 0;
      end
      m_grants = '0;
      m_busy   = '0;
      m_err    = 0;
    end else begin
      m_err = 0;
      for (int i = 0; i < 5; i++)
        if (tif.buf_req[i] && int'(tif.buf_dest[i]) >= 5)
          m_err = 1;
      for (int o = 0; o < 5; o++) begin
        if (m_lock[o]) begin
          if (tif.buf_ack[m_own[o]] && tif.buf_tail[m_own[o]]) begin
            m_lock[o] = 0;
            m_ptr[o]  = (m_own[o] + 1) % 5;
          end
        end else begin
          hit = 0;
          for (int k = 0; k < 5; k++) begin
            j = (m_ptr[o] + k) % 5;
            if (!hit && tif.buf_req[j]
                && int'(tif.buf_dest[j]) == o && !m_grants[j]) begin
              hit       = 1;
              m_lock[o] = 1;
              m_own[o]  = j;
            end
          end
        end
      end
      nxt_g = '0;
      for (int o = 0; o < 5; o++) begin
        m_busy[o] = m_lock[o];
        if (m_lock[o]) nxt_g[m_own[o]] = 1;
      end
      m_grants = nxt_g;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    tif.buf_req  = '0;
    tif.buf_tail = '0;
    tif.buf_ack  = '0;
    for (int i = 0; i < 5; i++) tif.buf_dest[i] = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 2) rst = 1'b0;
      checks++;
      if (tif.buffer_grants !== 5'b0 || tif.out_busy !== 5'b0
          || tif.dest_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: grants=%b busy=%b err=%b want 0",
                 c, tif.buffer_grants, tif.out_busy, tif.dest_err);
      end
    end
  endtask

  task automatic test_single_packet;
    do_reset();
    tif.buf_req[1] = 1; tif.buf_dest[1] = 3'd3;
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00010 || tif.out_busy !== 5'b01000) begin
      errors++;
      $display("FAIL single_grant: grants=%b busy=%b want 00010 01000",
               tif.buffer_grants, tif.out_busy);
    end
    tif.buf_ack[1] = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (tif.buffer_grants !== 5'b00010) begin
        errors++;
        $display("FAIL single_hold: grants=%b want 00010",
                 tif.buffer_grants);
      end
    end
    tif.buf_tail[1] = 1;
    tick();
    clear_inputs();
    checks++;
    if (tif.buffer_grants !== 5'b0 || tif.out_busy !== 5'b0) begin
      errors++;
      $display("FAIL single_release: grants=%b busy=%b want 0 0",
               tif.buffer_grants, tif.out_busy);
    end
    // ptr[3] is now 2: buffer 2 beats buffers 0 and 1
    for (int i = 0; i < 3; i++) begin
      tif.buf_req[i] = 1; tif.buf_dest[i] = 3'd3;
    end
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00100) begin
      errors++;
      $display("FAIL single_ptr: grants=%b want 00100",
               tif.buffer_grants);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    int order [4] = '{0, 2, 4, 0};
    do_reset();
    for (int i = 0; i < 5; i += 2) begin
      tif.buf_req[i] = 1; tif.buf_dest[i] = 3'd1;
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (tif.buffer_grants !== 5'(1 << order[n])
          || tif.out_busy !== 5'b00010) begin
        errors++;
        $display("FAIL rr_grant%0d: grants=%b busy=%b want %b 00010",
                 n, tif.buffer_grants, tif.out_busy, 5'(1 << order[n]));
      end
      tif.buf_ack  = 5'(1 << order[n]);
      tif.buf_tail = 5'(1 << order[n]);
      tick();
      tif.buf_ack  = '0;
      tif.buf_tail = '0;
      checks++;
      if (tif.buffer_grants !== 5'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: grants=%b want 00000",
                 n, tif.buffer_grants);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wraparound;
    do_reset();
    tif.buf_req[3] = 1; tif.buf_dest[3] = 3'd2;
    tick();
    tif.buf_ack[3] = 1; tif.buf_tail[3] = 1;
    tick();
    clear_inputs();
    tif.buf_req[0] = 1; tif.buf_dest[0] = 3'd2;
    tif.buf_req[4] = 1; tif.buf_dest[4] = 3'd2;
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b10000) begin
      errors++;
      $display("FAIL wrap_4: grants=%b want 10000", tif.buffer_grants);
    end
    tif.buf_req[4] = 0;
    tif.buf_ack[4] = 1; tif.buf_tail[4] = 1;
    tick();
    tif.buf_ack = '0; tif.buf_tail = '0;
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00001) begin
      errors++;
      $display("FAIL wrap_0: grants=%b want 00001", tif.buffer_grants);
    end
    clear_inputs();
  endtask

  task automatic test_parallel_lock;
    do_reset();
    tif.buf_req[0] = 1; tif.buf_dest[0] = 3'd4;
    tif.buf_req[1] = 1; tif.buf_dest[1] = 3'd0;
    tif.buf_req[2] = 1; tif.buf_dest[2] = 3'd4;
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00011 || tif.out_busy !== 5'b10001) begin
      errors++;
      $display("FAIL par_grant: grants=%b busy=%b want 00011 10001",
               tif.buffer_grants, tif.out_busy);
    end
    tif.buf_req[0] = 0; tif.buf_req[1] = 0;
    tif.buf_ack[0] = 1;
    tif.buf_ack[1] = 1; tif.buf_tail[1] = 1;
    tick();
    tif.buf_ack = '0; tif.buf_tail = '0;
    checks++;
    if (tif.buffer_grants !== 5'b00001 || tif.out_busy !== 5'b10000) begin
      errors++;
      $display("FAIL par_lock: grants=%b busy=%b want 00001 10000",
               tif.buffer_grants, tif.out_busy);
    end
    tick();
    tif.buf_ack[0] = 1; tif.buf_tail[0] = 1;
    tick();
    tif.buf_ack = '0; tif.buf_tail = '0;
    checks++;
    if (tif.buffer_grants !== 5'b0) begin
      errors++;
      $display("FAIL par_release: grants=%b want 00000",
               tif.buffer_grants);
    end
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00100 || tif.out_busy !== 5'b10000) begin
      errors++;
      $display("FAIL par_next: grants=%b busy=%b want 00100 10000",
               tif.buffer_grants, tif.out_busy);
    end
    clear_inputs();
  endtask

  task automatic test_dest_err;
    do_reset();
    tif.buf_req[3] = 1; tif.buf_dest[3] = 3'd6;
    tick();
    tif.buf_req[3] = 0;
    checks++;
    if (tif.dest_err !== 1'b1 || tif.buffer_grants !== 5'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b grants=%b want 1 00000",
               tif.dest_err, tif.buffer_grants);
    end
    tick();
    checks++;
    if (tif.dest_err !== 1'b0 || tif.buffer_grants !== 5'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b grants=%b want 0 00000",
               tif.dest_err, tif.buffer_grants);
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset;
    do_reset();
    tif.buf_req[2] = 1; tif.buf_dest[2] = 3'd0;
    tick();
    tif.buf_ack[2] = 1; tif.buf_tail[2] = 1;
    tick();
    clear_inputs();
    tif.buf_req[2] = 1; tif.buf_dest[2] = 3'd0;
    tif.buf_req[4] = 1; tif.buf_dest[4] = 3'd0;
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b10000) begin
      errors++;
      $display("FAIL mid_pre: grants=%b want 10000", tif.buffer_grants);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tif.buffer_grants !== 5'b0 || tif.out_busy !== 5'b0) begin
      errors++;
      $display("FAIL mid_rst: grants=%b busy=%b want 0 0",
               tif.buffer_grants, tif.out_busy);
    end
    tick();
    checks++;
    if (tif.buffer_grants !== 5'b00100) begin
      errors++;
      $display("FAIL mid_ptr0: grants=%b want 00100", tif.buffer_grants);
    end
    clear_inputs();
  endtask

  task automatic test_random;
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        tif.buf_req[i] = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 15);
        tif.buf_dest[i] = (r < 13) ? 3'(r % 5) : 3'(r - 8);
        tif.buf_tail[i] = $urandom_range(0, 1) == 1;
        if (m_grants[i])
          tif.buf_ack[i] = ($urandom_range(0, 9) < 6);
        else
          tif.buf_ack[i] = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (tif.buffer_grants !== m_grants || tif.out_busy !== m_busy
          || tif.dest_err !== m_err) begin
        errors++;
        $display("FAIL rand c%0d: g=%b b=%b e=%b want %b %b %b",
                 c, tif.buffer_grants, tif.out_busy, tif.dest_err,
                 m_grants, m_busy, m_err);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wraparound();
    test_parallel_lock();
    test_dest_err();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
Sequencing/arbitration controller for the 5-port crossbar switch. Collects per-input-buffer requests with a destination port and drives the switch's `buffer_grants` vector. One round-robin arbiter per output port. Wormhole locking holds an output for one owner from grant until the owner's tail flit is acknowledged. Sits between the input buffers and the switch; the switch's `dests` input comes from the same `buf_dest` bus.

Parameters:
- NUM_PORTS, 5, number of input buffers and output ports (fixed at 5 for this router; other values unsupported).
- DEST_WIDTH, 3, width of a destination port index.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- buf_req  input  [NUM_PORTS-1:0]  buffer i holds a flit to send.
- buf_dest  input  [DEST_WIDTH-1:0] [0:NUM_PORTS-1]  requested output port of buffer i; valid only while buf_req[i]=1.
- buf_tail  input  [NUM_PORTS-1:0]  current flit of buffer i is the packet's last.
- buf_ack  input  [NUM_PORTS-1:0]  switch acknowledged a flit from buffer i this cycle (the switch's per-buffer ack).
- buffer_grants  output  [NUM_PORTS-1:0]  registered; buffer i may transfer; connects to the switch.
- out_busy  output  [NUM_PORTS-1:0]  registered; output o is locked to an owner.
- dest_err  output  1  registered one-cycle pulse: some requesting buffer has buf_dest >= NUM_PORTS.

Behaviour:
- Reset (rst=1 at an edge): buffer_grants=0, out_busy=0, dest_err=0, all owner regs=0, all RR pointers=0. Applies mid-packet too; any in-flight lock is dropped.
- Per output o: 2-state FSM IDLE / LOCKED, plus owner[o] (3b) and ptr[o] (3b, range 0..4).
- IDLE, candidate set: {i | buf_req[i] && buf_dest[i]==o && !buffer_grants[i]}.
  - If non-empty: pick the first candidate scanning i = ptr[o], ptr[o]+1, ... mod 5.
  - Next cycle: owner[o]=winner, FSM->LOCKED, buffer_grants[winner]=1, out_busy[o]=1.
- Grant latency: request visible at cycle N -> grant high at N+1.
- LOCKED: buffer_grants[owner] held high regardless of buf_req or buf_dest changes.
  - buf_ack[owner] && !buf_tail[owner]: stay LOCKED.
  - buf_ack[owner] && buf_tail[owner] at cycle N: grant and out_busy drop at N+1; FSM->IDLE; ptr[o]=(owner+1) mod 5 (wrap 4->0).
- Earliest regrant of a released output is N+2, with no same-cycle handover. A bench may check for one idle cycle.
- buf_ack on a buffer with no grant is ignored.
- A buffer holds at most one grant, since it has one dest. Two outputs never grant the same buffer.
- Outputs arbitrate independently. Up to 5 grants may be active simultaneously when destinations are distinct.
- buf_dest >= 5 with buf_req: the request is excluded from all candidate sets, and dest_err pulses the next cycle. No lock is taken.
- ptr[o] changes only on release, never on grant. A buffer that never receives a tail ack holds its output indefinitely; no timeout.
- Simultaneous release of output o and a new request for o: the request is handled at the IDLE cycle per the rules above.

Decomposition:
- Shared package router_pkg holds:
  - NUM_PORTS, DEST_WIDTH;
  - the alloc_state_e enum {ALLOC_IDLE, ALLOC_LOCKED};
  - the port-index type port_idx_t.
- One sub-module, rr_arbiter: combinational NUM_PORTS-way round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and valid.
  - Instantiated once per output inside a generate loop.
- FSM, owner and pointer registers stay in switch_allocator.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 -> buffer_grants=0, out_busy=0, dest_err=0 throughout.
- Single packet: buf_req[1]=1, dest[1]=3 at cycle 0 -> grants=5'b00010 and out_busy[3]=1 at cycle 1. Acks at cycles 2 and 3, with tail at cycle 4 -> grants=0 at cycle 5; ptr[3]=2.
- Round-robin fairness: buffers 0, 2, 4 all requesting dest 1, each sending 1-flit packets (ack+tail the cycle after grant). Grant order is 0, 2, 4, 0 with one idle cycle between grants.
- Wrap-around: ptr[2]=4 after buffer 3 releases; buffers 0 and 4 request dest 2 -> buffer 4 wins; after its release ptr=0 and buffer 0 wins.
- Parallel and locking: buffer 0->dest 4 and buffer 1->dest 0 both granted at cycle 1. Buffer 2->dest 4 is not granted until buffer 0's tail ack, even if buffer 0 drops buf_req meanwhile.
- Error and reset: buf_req[3]=1 with dest=6 -> dest_err=1 for one cycle, no grant. rst=1 mid-packet -> grants=0 the next cycle, and arbitration restarts from ptr=0.
